// File: rtl/data_memory_pkg.sv
// Shared constants and types for the datapath data memory.
package data_memory_pkg;

  localparam int unsigned DATA_WIDTH = 72;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned DEPTH      = 128;

  // Position of the destination-register field inside the instruction word.
  localparam int unsigned RD_MSB = 54;
  localparam int unsigned RD_LSB = 48;

  typedef logic [DATA_WIDTH-1:0] mem_word_t;
  typedef logic [ADDR_WIDTH-1:0] mem_addr_t;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Data memory for the write-back/memory stage: ALU results are stored at the
// destination-register address, with one registered, write-first read port.
// The array stays directly under this module so it can be probed as
// <instance>.datamemory[n].
module data_memory
  import data_memory_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic [RD_MSB:RD_LSB]   register_destination_address,
  input  logic [DATA_WIDTH-1:0]  ALU_Result,
  input  logic [ADDR_WIDTH-1:0]  read_address,
  output logic [DATA_WIDTH-1:0]  read_data
);

  // The field range and the address width must describe the same bits, and the
  // array must cover the whole address space (no wrap handling exists).
  if ((RD_MSB - RD_LSB + 1) != ADDR_WIDTH || DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_cfg
    mem_addr_t cfg_mismatch_marker_does_not_exist = cfg_mismatch_marker_does_not_exist;
  end

  mem_addr_t wr_addr;
  mem_word_t datamemory [0:DEPTH-1];
  mem_word_t read_data_d;
  mem_word_t read_data_q;

  // Re-base the instruction field to a plain 0..DEPTH-1 index.
  assign wr_addr = mem_addr_t'(register_destination_address);

  // Storage: synchronous clear of every entry, otherwise a full-word write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        datamemory[ADDR_WIDTH'(i)] <= '0;
      end
    end else if (write_enable) begin
      datamemory[wr_addr] <= ALU_Result;
    end
  end

  // Read mux with write-first bypass when the read hits the word being written.
  always_comb begin
    read_data_d = datamemory[read_address];
    if (write_enable && (wr_addr == read_address)) begin
      read_data_d = ALU_Result;
    end
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory with a reference array model.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [54:48] register_destination_address;
  logic [71:0] ALU_Result;
  logic [6:0]  read_address;
  logic [71:0] read_data;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents and the value the read port should show.
  logic [71:0] ref_mem [128];
  logic [71:0] ref_rd;

  data_memory dut (
    .clk                          (clk),
    .reset                        (reset),
    .write_enable                 (write_enable),
    .register_destination_address (register_destination_address),
    .ALU_Result                   (ALU_Result),
    .read_address                 (read_address),
    .read_data                    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model by one edge, sample after the edge.
  task automatic drive(input logic rst, input logic we, input logic [6:0] wa,
                       input logic [71:0] wd, input logic [6:0] ra);
    reset = rst;
    write_enable = we;
    register_destination_address = wa;
    ALU_Result = wd;
    read_address = ra;
    if (rst) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = '0;
      ref_rd = '0;
    end else begin
      if (we) ref_mem[wa] = wd;
      ref_rd = ref_mem[ra];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 7'd0, '0, 7'd0);
    drive(1'b0, 1'b0, 7'd0, '0, 7'd0);
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (dut.datamemory[i] !== 72'h0) begin
        errors++;
        $display("FAIL reset_entry[%0d] got %h want 0", i, dut.datamemory[i]);
      end
    end
    checks++;
    if (read_data !== 72'h0) begin
      errors++;
      $display("FAIL reset_read_data got %h want 0", read_data);
    end
  endtask

  task automatic test_sequential_writes();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 7'(i), 72'(10 * i), 7'd0);
    checks++;
    if (dut.datamemory[6] !== 72'h3C) begin
      errors++;
      $display("FAIL seq_entry6 got %h want %h", dut.datamemory[6], 72'h3C);
    end
    checks++;
    if (dut.datamemory[9] !== 72'h5A) begin
      errors++;
      $display("FAIL seq_entry9 got %h want %h", dut.datamemory[9], 72'h5A);
    end
    for (int i = 10; i < 128; i++) begin
      checks++;
      if (dut.datamemory[i] !== 72'h0) begin
        errors++;
        $display("FAIL seq_untouched[%0d] got %h want 0", i, dut.datamemory[i]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 7'd6, {72{1'b1}}, 7'd6);
    checks++;
    if (dut.datamemory[6] !== 72'h3C) begin
      errors++;
      $display("FAIL hold_entry6 got %h want %h", dut.datamemory[6], 72'h3C);
    end
    checks++;
    if (read_data !== 72'h3C) begin
      errors++;
      $display("FAIL hold_read6 got %h want %h", read_data, 72'h3C);
    end
  endtask

  task automatic test_write_first();
    drive(1'b0, 1'b1, 7'd127, 72'h123456789ABCDEF012, 7'd127);
    checks++;
    if (read_data !== 72'h123456789ABCDEF012) begin
      errors++;
      $display("FAIL write_first_127 got %h want %h", read_data, 72'h123456789ABCDEF012);
    end
    checks++;
    if (dut.datamemory[127] !== 72'h123456789ABCDEF012) begin
      errors++;
      $display("FAIL entry127 got %h want %h", dut.datamemory[127], 72'h123456789ABCDEF012);
    end
    // Write elsewhere while reading 6: the old stored value must come back.
    drive(1'b0, 1'b1, 7'd7, 72'hDEAD, 7'd6);
    checks++;
    if (read_data !== 72'h3C) begin
      errors++;
      $display("FAIL read_other_addr got %h want %h", read_data, 72'h3C);
    end
  endtask

  task automatic test_full_width();
    drive(1'b0, 1'b1, 7'd0, 72'hFF_0000_0000_0000_0001, 7'd1);
    drive(1'b0, 1'b0, 7'd0, '0, 7'd0);
    checks++;
    if (read_data !== 72'hFF_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL full_width_read got %h want %h", read_data, 72'hFF_0000_0000_0000_0001);
    end
    checks++;
    if (dut.datamemory[0][71] !== 1'b1 || dut.datamemory[0][0] !== 1'b1) begin
      errors++;
      $display("FAIL full_width_bits got %h want msb=1 lsb=1", dut.datamemory[0]);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b1, 7'd5, 72'h55, 7'd5);
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (dut.datamemory[i] !== 72'h0) begin
        errors++;
        $display("FAIL reset_prio_entry[%0d] got %h want 0", i, dut.datamemory[i]);
      end
    end
    checks++;
    if (read_data !== 72'h0) begin
      errors++;
      $display("FAIL reset_prio_read got %h want 0", read_data);
    end
  endtask

  task automatic test_random();
    logic        rst, we;
    logic [6:0]  wa, ra;
    logic [95:0] raw;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 2) != 0);
      // Narrow address window on some cycles to force read/write collisions.
      wa  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
      ra  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
      if ($urandom_range(0, 9) == 0) ra = wa;
      if ($urandom_range(0, 19) == 0) wa = 7'd127;
      raw = {$urandom(), $urandom(), $urandom()};
      drive(rst, we, wa, raw[71:0], ra);
      checks++;
      if (read_data !== ref_rd) begin
        errors++;
        $display("FAIL rand_read[%0d] addr %0d got %h want %h", n, ra, read_data, ref_rd);
      end
      checks++;
      if (dut.datamemory[wa] !== ref_mem[wa]) begin
        errors++;
        $display("FAIL rand_entry[%0d] addr %0d got %h want %h", n, wa, dut.datamemory[wa], ref_mem[wa]);
      end
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (dut.datamemory[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL rand_final[%0d] got %h want %h", i, dut.datamemory[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    write_enable = 1'b0;
    register_destination_address = '0;
    ALU_Result = '0;
    read_address = '0;
    @(negedge clk);
    test_reset();
    test_sequential_writes();
    test_hold();
    test_write_first();
    test_full_width();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_memory
